// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if
// ------------
// Request/response bundle for the sram_ctrl storage block.
//
// Signals:
//   chip_enable_n   request strobe, active-low                (master -> slave)
//   write_enable_n  write request, active-low                 (master -> slave)
//   read_enable_n   read request, active-low                  (master -> slave)
//   address         word address, ADDR_WIDTH bits             (master -> slave)
//   data_in         write data, DATA_WIDTH bits               (master -> slave)
//   byte_en         per-byte write mask, DATA_WIDTH/8 bits    (master -> slave)
//   req_ready       block accepts a request this cycle        (slave -> master)
//   rd_valid        one-cycle read data pulse                 (slave -> master)
//   data_out        read data, held between pulses            (slave -> master)
//   init_done       clear sweep finished or skipped           (slave -> master)
//   error           sticky illegal-request flag               (slave -> master)
//
// Modports: master (requester side), slave (sram_ctrl side).

interface sram_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();

    localparam int BYTES = DATA_WIDTH / 8;

    logic                  chip_enable_n;
    logic                  write_enable_n;
    logic                  read_enable_n;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [BYTES-1:0]      byte_en;
    logic                  req_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  init_done;
    logic                  error;

    modport master (
        output chip_enable_n,
        output write_enable_n,
        output read_enable_n,
        output address,
        output data_in,
        output byte_en,
        input  req_ready,
        input  rd_valid,
        input  data_out,
        input  init_done,
        input  error
    );

    modport slave (
        input  chip_enable_n,
        input  write_enable_n,
        input  read_enable_n,
        input  address,
        input  data_in,
        input  byte_en,
        output req_ready,
        output rd_valid,
        output data_out,
        output init_done,
        output error
    );

endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl
// ---------
// Parametrised single-port synchronous SRAM with a request/ready handshake,
// per-byte write enables, a READ_LATENCY-deep read pipeline and an optional
// power-on clear sweep that writes INIT_VALUE to every word before the block
// starts accepting requests. A request with both read and write enables low
// is rejected and latches a sticky error flag.
//
// Ports:
//   clk    rising-edge clock for every register
//   reset  synchronous reset, active-high
//   bus    sram_ctrl_if.slave: request inputs (chip_enable_n, write_enable_n,
//          read_enable_n, address, data_in, byte_en) and status/response
//          outputs (req_ready, rd_valid, data_out, init_done, error)
//
// Parameters:
//   ADDR_WIDTH     word address bits; MEM_SIZE = 1 << ADDR_WIDTH
//   DATA_WIDTH     word width, a multiple of 8
//   READ_LATENCY   cycles from accept edge to the rd_valid cycle, 1..4
//   INIT_ON_RESET  1: clear the array after reset; 0: skip the sweep
//   INIT_VALUE     word written everywhere during the sweep

module sram_ctrl #(
    parameter int                    ADDR_WIDTH    = 8,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    READ_LATENCY  = 2,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input logic        clk,
    input logic        reset,
    sram_ctrl_if.slave bus
);

    localparam int MEM_SIZE = 1 << ADDR_WIDTH;
    localparam int BYTES    = DATA_WIDTH / 8;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  ready_q;
    logic                  error_q;

    logic                  init_we;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  illegal;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  rd_vld_p  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] rd_data_p [READ_LATENCY];

    // ------------------------------------------------------------------
    // State register, sweep counter and registered ready flag.
    // ready_q follows the next state so that req_ready/init_done stay low
    // in the cycle after reset even when the sweep is skipped, and rise
    // right after the edge that writes the last word when it is not.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_ON_RESET ? S_INIT : S_READY;
            init_addr <= '0;
            ready_q   <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == S_READY);
            if (state == S_INIT) begin
                init_addr <= init_addr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: the sweep ends on the edge that writes the top word.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_INIT: begin
                if (init_addr == '1) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                state_next = S_READY;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output/strobe decode. Requests are only honoured when req_ready is
    // already high, so anything presented during the sweep is dropped.
    // Reset also blocks acceptance so a request on a reset edge is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        init_we   = 1'b0;
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            if (state == S_INIT) begin
                init_we = 1'b1;
            end else if (ready_q && !bus.chip_enable_n) begin
                wr_accept = !bus.write_enable_n &&  bus.read_enable_n;
                rd_accept =  bus.write_enable_n && !bus.read_enable_n;
                illegal   = !bus.write_enable_n && !bus.read_enable_n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array: sweep writes take the whole word, request writes merge
    // only the enabled bytes. byte_en == 0 leaves the word untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= INIT_VALUE;
        end else if (wr_accept) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.byte_en[i]) begin
                    mem[bus.address][8*i +: 8] <= bus.data_in[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 captures the array word at the accept edge;
    // each later stage loads only when a valid word arrives, so the last
    // stage doubles as the data_out holding register between pulses.
    // Reset flushes the valids, dropping any read still in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_vld_p[i]  <= 1'b0;
                rd_data_p[i] <= '0;
            end
        end else begin
            rd_vld_p[0] <= rd_accept;
            if (rd_accept) begin
                rd_data_p[0] <= mem[bus.address];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
                if (rd_vld_p[i-1]) begin
                    rd_data_p[i] <= rd_data_p[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error: set by any request with both enables low, cleared only
    // by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (illegal) begin
            error_q <= 1'b1;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.init_done = ready_q;
    assign bus.rd_valid  = rd_vld_p[READ_LATENCY-1];
    assign bus.data_out  = rd_data_p[READ_LATENCY-1];
    assign bus.error     = error_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
// ------------
// Directed bench for sram_ctrl with ADDR_WIDTH=4, DATA_WIDTH=32,
// READ_LATENCY=2, INIT_ON_RESET=1, INIT_VALUE=0xA5A5A5A5.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every expected read is queued with the falling-edge index at which its
// rd_valid pulse must appear, and each tick checks rd_valid against the queue.

module tb_sram_ctrl;

    localparam int          AW = 4;
    localparam int          DW = 32;
    localparam int          RL = 2;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .INIT_ON_RESET(1'b1),
        .INIT_VALUE   (IV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge and check rd_valid against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_valid_cycle", cyc, e.cyc);
                chk("rd_data", bus.data_out, e.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
        end
    endtask

    task automatic set_idle();
        bus.chip_enable_n  = 1'b1;
        bus.write_enable_n = 1'b1;
        bus.read_enable_n  = 1'b1;
        bus.address        = '0;
        bus.data_in        = '0;
        bus.byte_en        = '0;
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.chip_enable_n  = 1'b0;
        bus.write_enable_n = 1'b0;
        bus.read_enable_n  = 1'b1;
        bus.address        = a;
        bus.data_in        = d;
        bus.byte_en        = be;
        tick();
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [31:0] expv);
        exp_t e;
        bus.chip_enable_n  = 1'b0;
        bus.write_enable_n = 1'b1;
        bus.read_enable_n  = 1'b0;
        bus.address        = a;
        bus.data_in        = '0;
        bus.byte_en        = '0;
        e.cyc  = cyc + RL;
        e.data = expv;
        exp_q.push_back(e);
        tick();
    endtask

    // Counts falling edges with req_ready low, starting at the one where
    // reset is released; the sweep must hold it low for exactly 16.
    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (bus.req_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk(tag, cnt, 32'd16);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
        chk({tag, "_rd_valid"},  {31'd0, bus.rd_valid},  32'd0);
        chk({tag, "_data_out"},  bus.data_out,           32'd0);
        chk({tag, "_init_done"}, {31'd0, bus.init_done}, 32'd0);
        chk({tag, "_error"},     {31'd0, bus.error},     32'd0);
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;

        // Clear sweep then read back every word.
        wait_ready("init_sweep_len");
        chk("init_done", {31'd0, bus.init_done}, 32'd1);
        chk("error_after_init", {31'd0, bus.error}, 32'd0);
        for (int i = 0; i < 16; i++) drive_read(AW'(i), IV);
        idle(3);

        // Write then read on the next cycle; data_out holds afterwards.
        drive_write(4'd3, 32'h11223344, 4'hF);
        drive_read(4'd3, 32'h11223344);
        idle(3);
        chk("hold_data_out", bus.data_out, 32'h11223344);
        chk("hold_rd_valid_low", {31'd0, bus.rd_valid}, 32'd0);

        // Partial byte merge.
        drive_write(4'd7, 32'h00000000, 4'hF);
        drive_write(4'd7, 32'hFFFFFFFF, 4'b0101);
        drive_read(4'd7, 32'h00FF00FF);
        idle(3);

        // Back-to-back reads.
        drive_write(4'd0, 32'd0,  4'hF);
        drive_write(4'd1, 32'd10, 4'hF);
        drive_write(4'd2, 32'd20, 4'hF);
        drive_write(4'd3, 32'd30, 4'hF);
        drive_read(4'd0, 32'd0);
        drive_read(4'd1, 32'd10);
        drive_read(4'd2, 32'd20);
        drive_read(4'd3, 32'd30);
        idle(4);

        // byte_en == 0 write is a no-op.
        drive_write(4'd3, 32'hFFFFFFFF, 4'h0);
        drive_read(4'd3, 32'd30);
        idle(3);

        // Illegal request: both enables low.
        drive_write(4'd5, 32'h5, 4'hF);
        idle(1);
        chk("error_before_illegal", {31'd0, bus.error}, 32'd0);
        bus.chip_enable_n  = 1'b0;
        bus.write_enable_n = 1'b0;
        bus.read_enable_n  = 1'b0;
        bus.address        = 4'd5;
        bus.data_in        = 32'hDEADBEEF;
        bus.byte_en        = 4'hF;
        tick();
        chk("error_rise", {31'd0, bus.error}, 32'd1);
        idle(3);
        chk("error_sticky", {31'd0, bus.error}, 32'd1);
        drive_read(4'd5, 32'h5);
        idle(3);
        chk("error_still_set", {31'd0, bus.error}, 32'd1);

        // Reset with reads in flight: neither may produce rd_valid.
        bus.chip_enable_n  = 1'b0;
        bus.write_enable_n = 1'b1;
        bus.read_enable_n  = 1'b0;
        bus.address        = 4'd1;
        tick();
        bus.address = 4'd2;
        reset       = 1'b1;
        tick();
        set_idle();
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        wait_ready("resweep_len");
        chk("error_cleared", {31'd0, bus.error}, 32'd0);
        drive_read(4'd3, IV);
        drive_read(4'd15, IV);
        idle(4);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised single-port synchronous SRAM with a request/ready handshake, per-byte write enables, a configurable read pipeline and a power-on clear engine. It replaces the fixed 8×256 SRAM as the general on-chip storage block. Memory access is gated until the optional clear sweep completes. Illegal simultaneous read and write requests are flagged with a sticky error bit.

## Interface
- ADDR_WIDTH, 8, address bits; MEM_SIZE = 1<<ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8; BYTES = DATA_WIDTH/8
- READ_LATENCY, 2, read latency in cycles; legal range 1..4
- INIT_ON_RESET, 1, when 1, clear all words after reset; when 0, leave contents undefined
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during the clear sweep

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; every register updates on its rising edge
- reset  in  1  synchronous reset, active-high
- chip_enable_n  in  1  request strobe, active-low
- write_enable_n  in  1  write request, active-low
- read_enable_n  in  1  read request, active-low
- address  in  ADDR_WIDTH  word address
- data_in  in  DATA_WIDTH  write data
- byte_en  in  BYTES  per-byte write mask; bit i covers data bits [8i+7:8i]
- req_ready  out  1  block is ready to accept a request
- rd_valid  out  1  one-cycle pulse; data_out holds read data in this cycle
- data_out  out  DATA_WIDTH  read data
- init_done  out  1  clear sweep finished (or skipped)
- error  out  1  sticky illegal-request flag

## Operation
- State machine has two states, INIT and READY. Reset enters INIT when INIT_ON_RESET=1, otherwise READY.
- INIT:
  - An address counter starts at 0 and writes INIT_VALUE to one word per cycle.
  - After the edge that writes word MEM_SIZE-1, the state moves to READY.
  - req_ready=0 throughout INIT, and all requests are ignored.
- READY: req_ready=1 and init_done=1. A request is accepted on an edge where chip_enable_n=0 and req_ready=1.
  - Write (write_enable_n=0, read_enable_n=1):
    - Each byte with byte_en[i]=1 is updated at that edge.
    - Bytes with byte_en[i]=0 keep their old value.
    - byte_en=0 is a legal no-op write.
  - Read (read_enable_n=0, write_enable_n=1): the word enters a READ_LATENCY-deep pipeline.
  - Both enables low: no memory access, and error is set to 1. error stays set until reset.
  - Both enables high: no operation.
- Throughput is one request per cycle. Back-to-back reads may be issued every cycle, and rd_valid then stays high continuously.
- Write-then-read: a read of address A presented in the cycle after a write to A returns the new data, including partial byte merges.
- data_out holds the last read value between rd_valid pulses.
- Reset mid-operation:
  - The read pipeline is flushed; reads in flight never produce rd_valid.
  - The error flag is cleared.
  - The state returns to INIT and the clear sweep restarts at address 0 (when INIT_ON_RESET=1).

## Timing
- Output values during reset and in the cycle after it: req_ready=0, rd_valid=0, data_out=0, init_done=0, error=0.
- E0 is the first rising edge with reset low.
  - With INIT_ON_RESET=1: edge Ek writes word k for k=0..MEM_SIZE-1. req_ready and init_done become 1 after edge E(MEM_SIZE-1).
  - With INIT_ON_RESET=0: req_ready and init_done become 1 after edge E0.
- Read accepted at edge A: rd_valid=1 and data_out are valid during the cycle after edge A+READ_LATENCY-1.
  - With READ_LATENCY=1, data appears in the cycle right after the accept edge.
- Write accepted at edge A: the memory is updated at edge A, and a read accepted at edge A+1 sees the new data.
- error rises in the cycle after the first illegal request edge.

## Test plan
- INIT_ON_RESET=1, ADDR_WIDTH=4, INIT_VALUE=0xA5A5A5A5: release reset -> req_ready=0 for exactly 16 cycles, then 1. Read every address -> all return 0xA5A5A5A5.
- READY, READ_LATENCY=2: write 0x11223344 to addr 3, then read addr 3 on the next cycle -> rd_valid pulses 2 cycles after the read request, with data_out=0x11223344.
- Write 0xFFFFFFFF with byte_en=4'b0101 over 0x00000000 at addr 7, then read addr 7 -> data_out=0x00FF00FF.
- Issue reads of addr 0,1,2,3 in 4 consecutive cycles, containing 0,10,20,30 -> rd_valid high for 4 consecutive cycles with data 0,10,20,30 in order.
- chip_enable_n=0 with both enables low, on an address holding 0x5 -> error=1 next cycle and stays 1, memory unchanged (read returns 0x5), no rd_valid.
- Assert reset while 2 reads are in flight -> no rd_valid afterwards, error=0, and the clear sweep restarts (req_ready=0 for MEM_SIZE cycles).
